key_direction_decoder: RTL and testbench

Converts the byte stream from the PS/2 keyboard receiver into the frame-stable `left`, `right` and `invincible` control levels consumed by the player movement logic. It tracks make/break/extended prefixes, holds per-key pressed state and turns the invincibility key into a toggle. Outputs change only on `startOfFrame`, so the player sees exactly one decision per frame.

---
 rtl/keyboard_pkg.sv | 19 +
 rtl/scan_prefix_fsm.sv | 80 ++++++++
 rtl/key_direction_decoder.sv | 86 ++++++++
 tb/tb_key_direction_decoder.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/keyboard_pkg.sv
// rtl/keyboard_pkg.sv - shared PS/2 keyboard prefix constants, key codes and prefix FSM states
package keyboard_pkg;

  localparam logic [7:0] KB_EXT   = 8'hE0;
  localparam logic [7:0] KB_BRK   = 8'hF0;
  localparam logic [7:0] KB_PAUSE = 8'hE1;

  localparam logic [7:0] KB_LEFT_CODE  = 8'h6B;
  localparam logic [7:0] KB_RIGHT_CODE = 8'h74;
  localparam logic [7:0] KB_INV_CODE   = 8'h43;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } prefix_state_t;

endpackage

// File: rtl/scan_prefix_fsm.sv
// rtl/scan_prefix_fsm.sv - folds E0/F0/E1 prefixes into single key events with a prefix timeout
module scan_prefix_fsm
  import keyboard_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] scanCode,
  input  logic       scanValid,
  output logic       keyEvent,
  output logic       isBreak,
  output logic       isExt,
  output logic [7:0] code
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  prefix_state_t state;
  prefix_state_t next_state;
  logic [CW-1:0] count;

  // Events are combinational so the top can update its flags on the edge that accepts the byte.
  always_comb begin
    next_state = state;
    keyEvent   = 1'b0;
    isBreak    = 1'b0;
    isExt      = 1'b0;
    code       = scanCode;
    if (scanValid) begin
      case (state)
        IDLE: begin
          if (scanCode == KB_EXT)        next_state = EXT;
          else if (scanCode == KB_BRK)   next_state = BRK;
          else if (scanCode != KB_PAUSE) keyEvent   = 1'b1;
        end
        EXT: begin
          if (scanCode == KB_BRK) next_state = EXT_BRK;
          else if (scanCode != KB_EXT) begin
            keyEvent   = 1'b1;
            isExt      = 1'b1;
            next_state = IDLE;
          end
        end
        BRK: begin
          keyEvent   = 1'b1;
          isBreak    = 1'b1;
          next_state = IDLE;
        end
        EXT_BRK: begin
          keyEvent   = 1'b1;
          isBreak    = 1'b1;
          isExt      = 1'b1;
          next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // An accepted byte wins over a timeout landing in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else if (scanValid) begin
      state <= next_state;
      count <= '0;
    end else if (state != IDLE) begin
      if (count == LAST) begin
        state <= IDLE;
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_direction_decoder.sv
// rtl/key_direction_decoder.sv - turns PS/2 key events into frame-stable left/right/invincible levels
module key_direction_decoder
  import keyboard_pkg::*;
#(
  parameter logic [7:0] LEFT_CODE      = KB_LEFT_CODE,
  parameter logic [7:0] RIGHT_CODE     = KB_RIGHT_CODE,
  parameter logic [7:0] INV_CODE       = KB_INV_CODE,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] scanCode,
  input  logic       scanValid,
  input  logic       startOfFrame,
  output logic       left,
  output logic       right,
  output logic       invincible
);

  logic       keyEvent;
  logic       isBreak;
  logic       isExt;
  logic [7:0] code;

  logic heldL, heldR, heldI;
  logic sawL, sawR;
  logic invToggle;

  scan_prefix_fsm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_prefix (
    .clk      (clk),
    .reset    (reset),
    .scanCode (scanCode),
    .scanValid(scanValid),
    .keyEvent (keyEvent),
    .isBreak  (isBreak),
    .isExt    (isExt),
    .code     (code)
  );

  logic left_ev, right_ev, inv_ev;
  assign left_ev  = keyEvent &&  isExt && (code == LEFT_CODE);
  assign right_ev = keyEvent &&  isExt && (code == RIGHT_CODE);
  assign inv_ev   = keyEvent && !isExt && (code == INV_CODE);

  // Key updates come after the frame clear so a make in a frame-pulse cycle survives into next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      heldL      <= 1'b0;
      heldR      <= 1'b0;
      heldI      <= 1'b0;
      sawL       <= 1'b0;
      sawR       <= 1'b0;
      invToggle  <= 1'b0;
      left       <= 1'b0;
      right      <= 1'b0;
      invincible <= 1'b0;
    end else begin
      if (startOfFrame) begin
        left       <= heldL | sawL;
        right      <= heldR | sawR;
        invincible <= invToggle;
        sawL       <= 1'b0;
        sawR       <= 1'b0;
      end
      if (left_ev) begin
        heldL <= !isBreak;
        if (!isBreak) sawL <= 1'b1;
      end
      if (right_ev) begin
        heldR <= !isBreak;
        if (!isBreak) sawR <= 1'b1;
      end
      if (inv_ev) begin
        if (isBreak) begin
          heldI <= 1'b0;
        end else if (!heldI) begin
          heldI     <= 1'b1;
          invToggle <= !invToggle;
        end
      end
    end
  end

endmodule

// File: tb/tb_key_direction_decoder.sv
// tb/tb_key_direction_decoder.sv - directed scoreboard bench for key_direction_decoder
module tb_key_direction_decoder;

  localparam int TOUT = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] scanCode;
  logic       scanValid;
  logic       startOfFrame;
  logic       left, right, invincible;

  int checks = 0;
  int errors = 0;

  logic [2:0] exp_q[$];
  string      tag_q[$];

  key_direction_decoder #(
    .LEFT_CODE     (8'h6B),
    .RIGHT_CODE    (8'h74),
    .INV_CODE      (8'h43),
    .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .scanCode    (scanCode),
    .scanValid   (scanValid),
    .startOfFrame(startOfFrame),
    .left        (left),
    .right       (right),
    .invincible  (invincible)
  );

  always #5 clk = ~clk;

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    scanCode  = b;
    scanValid = 1'b1;
    @(negedge clk);
    scanValid = 1'b0;
    scanCode  = 8'h00;
  endtask

  task automatic compare_head();
    logic [2:0] exp;
    logic [2:0] obs;
    string      tag;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: observed=empty expected=entry");
    end else begin
      exp = exp_q.pop_front();
      tag = tag_q.pop_front();
      obs = {left, right, invincible};
      checks++;
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s: observed lri=%b expected lri=%b", tag, obs, exp);
      end
    end
  endtask

  // Pulse startOfFrame, queue the expected {left,right,invincible}, and check after the edge.
  task automatic frame(input logic [2:0] exp, input string tag);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    compare_head();
  endtask

  initial begin
    reset        = 1'b1;
    scanCode     = 8'h00;
    scanValid    = 1'b0;
    startOfFrame = 1'b0;
    idle(3);

    exp_q.push_back(3'b000);
    tag_q.push_back("reset_outputs");
    compare_head();
    reset = 1'b0;
    idle(1);
    frame(3'b000, "frame_after_reset");

    send_byte(8'hE0); send_byte(8'h6B);
    frame(3'b100, "left_make");
    frame(3'b100, "left_held");
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
    frame(3'b000, "left_break");
    frame(3'b000, "left_stays_off");

    send_byte(8'hE0); send_byte(8'h74);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
    frame(3'b010, "right_tap");
    frame(3'b000, "right_tap_one_frame");

    send_byte(8'h74);
    send_byte(8'hE0); send_byte(8'h43);
    frame(3'b000, "nonext_right_ext_inv_ignored");

    send_byte(8'hE0); send_byte(8'h6B);
    send_byte(8'hE0); send_byte(8'h74);
    frame(3'b110, "both_held");
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
    frame(3'b000, "both_released");

    send_byte(8'h43); send_byte(8'h43); send_byte(8'h43);
    frame(3'b001, "inv_toggle_on_typematic");
    send_byte(8'hF0); send_byte(8'h43);
    frame(3'b001, "inv_break_keeps_level");
    send_byte(8'h43);
    frame(3'b000, "inv_toggle_off");

    send_byte(8'hE1); send_byte(8'hE0); send_byte(8'hE0); send_byte(8'h6B);
    frame(3'b100, "pause_dropped_repeat_e0");
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
    frame(3'b000, "pause_case_release");

    send_byte(8'hE0);
    idle(TOUT - 8);
    send_byte(8'h6B);
    frame(3'b100, "before_timeout_ext_make");
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
    frame(3'b000, "before_timeout_release");

    send_byte(8'hE0);
    idle(TOUT + 4);
    send_byte(8'h6B);
    frame(3'b000, "timeout_drops_prefix");

    send_byte(8'hE0);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    send_byte(8'h6B);
    frame(3'b000, "reset_discards_prefix");

    send_byte(8'hE0);
    exp_q.push_back(3'b000);
    tag_q.push_back("make_with_frame_pulse");
    scanCode     = 8'h6B;
    scanValid    = 1'b1;
    startOfFrame = 1'b1;
    @(negedge clk);
    scanValid    = 1'b0;
    startOfFrame = 1'b0;
    compare_head();
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
    frame(3'b100, "make_with_pulse_next_frame");
    frame(3'b000, "make_with_pulse_cleared");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
